// File: rtl/dsram_responder.sv
// dsram_responder: single-port 4-lane data SRAM with registered read data and programmable wait states.
// Define DSRAM_STATS_EN to add rd_count/wr_count/stall_count outputs.
module dsram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
`ifdef DSRAM_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count,
`endif
    output logic        stallreq
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic stall, perform;
    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic unused_addr;

    assign idx = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    // Reset overrides a pending request so the stall controller is released at once.
    assign stallreq = stall & resetn;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        perform    = 1'b0;
        case (state)
            IDLE: if (data_sram_en) begin
                if (WAIT_CYCLES == 0) begin
                    perform = 1'b1;
                end else begin
                    stall      = 1'b1;
                    state_next = WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            WAIT: begin
                if (!data_sram_en) begin
                    state_next = IDLE;
                end else if (cnt != 4'd0) begin
                    stall    = 1'b1;
                    cnt_next = cnt - 4'd1;
                end else begin
                    perform    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            data_sram_rdata <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (perform && data_sram_wen == 4'b0000)
                data_sram_rdata <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (perform && resetn && data_sram_wen[k])
                mem[idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
    end

`ifdef DSRAM_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_count    <= 32'h0;
            wr_count    <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (perform && data_sram_wen == 4'b0000)
                rd_count <= rd_count + 32'd1;
            if (perform && data_sram_wen != 4'b0000)
                wr_count <= wr_count + 32'd1;
            if (stallreq)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dsram_responder.sv
// tb_dsram_responder: drives a zero-wait and a three-wait instance with the same stimulus
// and checks both against an access-age model every cycle plus literal expectations.
module tb_dsram_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata0, rdata3;
    logic        stall0, stall3;
`ifdef DSRAM_STATS_EN
    logic [31:0] rdc0, wrc0, stc0, rdc3, wrc3, stc3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata0),
`ifdef DSRAM_STATS_EN
        .rd_count(rdc0), .wr_count(wrc0), .stall_count(stc0),
`endif
        .stallreq(stall0)
    );

    dsram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
`ifdef DSRAM_STATS_EN
        .rd_count(rdc3), .wr_count(wrc3), .stall_count(stc3),
`endif
        .stallreq(stall3)
    );

    // Model: an access held for N stall cycles performs on the (N+1)th cycle of en.
    int          nw [2] = '{0, 3};
    int          age [2];
    logic [31:0] mem [2][1024];
    logic [31:0] m_rd [2];
    logic [31:0] m_rdc [2], m_wrc [2], m_stc [2];

    function automatic bit m_stall(int d);
        return resetn && en && age[d] < nw[d];
    endfunction

    always @(posedge clk or negedge resetn) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                age[d] = 0; m_rd[d] = 32'h0; m_rdc[d] = 0; m_wrc[d] = 0; m_stc[d] = 0;
            end else begin
                if (m_stall(d)) m_stc[d] = m_stc[d] + 1;
                if (!en) begin
                    age[d] = 0;
                end else if (age[d] < nw[d]) begin
                    age[d] = age[d] + 1;
                end else begin
                    age[d] = 0;
                    if (wen == 4'h0) begin
                        m_rd[d] = mem[d][(addr % 4096) / 4];
                        m_rdc[d] = m_rdc[d] + 1;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            if (wen[k]) mem[d][(addr % 4096) / 4][8*k +: 8] = wdata[8*k +: 8];
                        m_wrc[d] = m_wrc[d] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("u0_stallreq", {31'h0, stall0}, {31'h0, m_stall(0)});
            chk("u0_rdata", rdata0, m_rd[0]);
            chk("u3_stallreq", {31'h0, stall3}, {31'h0, m_stall(1)});
            chk("u3_rdata", rdata3, m_rd[1]);
`ifdef DSRAM_STATS_EN
            chk("u0_rd_count", rdc0, m_rdc[0]);
            chk("u0_wr_count", wrc0, m_wrc[0]);
            chk("u0_stall_count", stc0, m_stc[0]);
            chk("u3_rd_count", rdc3, m_rdc[1]);
            chk("u3_wr_count", wrc3, m_wrc[1]);
            chk("u3_stall_count", stc3, m_stc[1]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold en for 'hold' cycles then idle one cycle; returns how many cycles u3 stalled.
    task automatic acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output int ns);
        ns = 0;
        en = 1'b1; wen = w; addr = a; wdata = d;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (stall3) ns++;
            step();
        end
        en = 1'b0;
        step();
    endtask

    initial begin
        int ns;
`ifdef DSRAM_STATS_EN
        logic [31:0] st_before, rd_before;
`endif
        step();
        step();
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_rdata3", rdata3, 32'h0);
        chk("reset_stall3", {31'h0, stall3}, 32'h0);
        resetn = 1'b1;
        step();

        acc(4'hF, 32'h10, 32'hDEADBEEF, 4, ns);
`ifdef DSRAM_STATS_EN
        st_before = stc3; rd_before = rdc3;
`endif
        acc(4'h0, 32'h10, 32'h0, 4, ns);
        chk("read10_u0", rdata0, 32'hDEADBEEF);
        chk("read10_u3", rdata3, 32'hDEADBEEF);
        chk("u3_stall_cycles", ns, 3);
`ifdef DSRAM_STATS_EN
        chk("u3_stall_delta", stc3 - st_before, 32'd3);
        chk("u3_rd_delta", rdc3 - rd_before, 32'd1);
`endif

        acc(4'hF, 32'h20, 32'h11223344, 4, ns);
        acc(4'b0100, 32'h20, 32'h00AA0000, 4, ns);
        acc(4'h0, 32'h22, 32'h0, 4, ns);
        chk("lane2_u0", rdata0, 32'h11AA3344);
        chk("lane2_u3", rdata3, 32'h11AA3344);
        acc(4'b0011, 32'h21, 32'h0000BBCC, 4, ns);
        acc(4'h0, 32'h20, 32'h0, 4, ns);
        chk("lane10_u0", rdata0, 32'h11AABBCC);
        chk("lane10_u3", rdata3, 32'h11AABBCC);

        acc(4'hF, 32'h30, 32'h0, 4, ns);
        acc(4'hF, 32'h30, 32'h12345678, 1, ns);
        chk("abort_stall_cycles", ns, 1);
        chk("abort_stall_after", {31'h0, stall3}, 32'h0);
        acc(4'h0, 32'h30, 32'h0, 4, ns);
        chk("abort_u0_written", rdata0, 32'h12345678);
        chk("abort_u3_kept", rdata3, 32'h0);

        acc(4'hF, 32'h40, 32'h55, 4, ns);
        en = 1'b1; wen = 4'hF; addr = 32'h40; wdata = 32'h99;
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata3", rdata3, 32'h0);
        chk("rst_stall3", {31'h0, stall3}, 32'h0);
        step();
        en = 1'b0;
        resetn = 1'b1;
        step();
        acc(4'h0, 32'h40, 32'h0, 4, ns);
        chk("rst_u0_written", rdata0, 32'h99);
        chk("rst_u3_kept", rdata3, 32'h55);
        chk("rst_u3_stall_cycles", ns, 3);

        acc(4'hF, 32'h1000, 32'hCAFEF00D, 4, ns);
        acc(4'h0, 32'h0000, 32'h0, 4, ns);
        chk("alias_u0", rdata0, 32'hCAFEF00D);
        chk("alias_u3", rdata3, 32'hCAFEF00D);

        acc(4'h0, 32'h10, 32'h0, 4, ns);
        chk("reread10_u3", rdata3, 32'hDEADBEEF);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
